fire_trap_decoder: RTL

- Standalone sequential error-trapping decoder for the (64,40) Fire code. It is the receive end of the encoder path in `system`.
- Accepts one 64-bit received word over a valid/ready handshake and computes its syndrome serially.
- Traps a single burst of length ≤ 8 by reverse-shifting the syndrome, corrects the burst, and returns the 40 data bits with status flags.

---
 rtl/fire_pkg.sv | 13 +
 rtl/fire_syndrome_lfsr.sv | 30 +++
 rtl/fire_trap_decoder.sv | 106 ++++++++++
 3 files changed

// File: rtl/fire_pkg.sv
// Shared constants and state types for the (64,40) Fire-code error-trapping decoder.
package fire_pkg;
    localparam int N = 64;
    localparam int K = 40;
    localparam int B = 8;
    localparam int R = 24;
    localparam int MAX_SHIFT = 56;
    // g(x) = (x^15+1)(x^9+x^4+1) = x^24+x^19+x^15+x^9+x^4+1
    localparam logic [R:0] G_POLY = 25'h108_8211;

    typedef enum logic [1:0] {IDLE, SYND, TRAP, OUT} state_t;
    typedef enum logic [1:0] {LFSR_HOLD, LFSR_CLEAR, LFSR_FWD, LFSR_REV} lfsr_mode_t;
endpackage

// File: rtl/fire_syndrome_lfsr.sv
// Syndrome register: forward division by g(x) while the word streams in,
// and reverse shifting (multiply by x^-1 mod g) while hunting for a burst.
module fire_syndrome_lfsr
    import fire_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  lfsr_mode_t   mode,
    input  logic         bit_in,
    output logic [R-1:0] s,
    output logic         trapped,
    output logic         zero
);
    always_ff @(posedge clk) begin
        if (rst) begin
            s <= '0;
        end else begin
            case (mode)
                LFSR_CLEAR: s <= '0;
                LFSR_FWD:   s <= {s[R-2:0], bit_in} ^ (s[R-1] ? G_POLY[R-1:0] : '0);
                // Odd s: add g so the division by x is exact; g's constant term clears bit 0.
                LFSR_REV:   s <= s[0] ? ((s >> 1) ^ G_POLY[R:1]) : (s >> 1);
                default:    s <= s;
            endcase
        end
    end

    assign trapped = (s[R-1:B] == '0);
    assign zero    = (s == '0);
endmodule

// File: rtl/fire_trap_decoder.sv
// Sequential error-trapping decoder: 64-cycle syndrome, up to 57 trap checks,
// single burst (<= 8 bits) correction, result held until consumed.
module fire_trap_decoder
    import fire_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] codeword_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [K-1:0] data_out,
    output logic         corrected,
    output logic         uncorrectable,
    output logic [5:0]   err_pos
);
    state_t       state, state_nxt;
    lfsr_mode_t   mode;
    logic [N-1:0] r;
    logic [5:0]   cnt;
    logic [5:0]   shift;
    logic [R-1:0] s;
    logic         trapped, zero, accept, at_limit;

    assign accept   = in_valid && (state == IDLE);
    assign at_limit = (shift == 6'(MAX_SHIFT));

    fire_syndrome_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .bit_in  (r[6'(N-1) - cnt]),
        .s       (s),
        .trapped (trapped),
        .zero    (zero)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mode      = LFSR_HOLD;
        case (state)
            IDLE: if (accept) begin
                state_nxt = SYND;
                mode      = LFSR_CLEAR;
            end
            SYND: begin
                mode = LFSR_FWD;
                if (cnt == 6'(N-1)) state_nxt = TRAP;
            end
            TRAP: begin
                if (trapped || at_limit) state_nxt = OUT;
                else                     mode      = LFSR_REV;
            end
            OUT: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r             <= '0;
            cnt           <= '0;
            shift         <= '0;
            corrected     <= 1'b0;
            uncorrectable <= 1'b0;
            err_pos       <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    r             <= codeword_in;
                    cnt           <= '0;
                    shift         <= '0;
                    corrected     <= 1'b0;
                    uncorrectable <= 1'b0;
                    err_pos       <= '0;
                end
                SYND: cnt <= cnt + 6'd1;
                TRAP: begin
                    // zero syndrome also satisfies trapped; leave r and flags alone then
                    if (zero) begin
                        r <= r;
                    end else if (trapped) begin
                        r         <= r ^ ({{(N-B){1'b0}}, s[B-1:0]} << shift);
                        corrected <= 1'b1;
                        err_pos   <= shift;
                    end else if (at_limit) begin
                        uncorrectable <= 1'b1;
                    end else begin
                        shift <= shift + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign data_out  = r[N-1:N-K];
endmodule
